// File: rtl/hazard_controller_if.sv
// Hazard controller handshake bundle between pipeline and controller.
// stall_count exists only when HAZARD_STALL_COUNT_EN is defined.
interface hazard_controller_if;
  logic       ID_RegRs;
  logic       ID_RegRt;
  logic       EX_RegRt;
  logic       EX_MemRead;
  logic       EX_BranchTaken;
  logic       MEM_MemAccess;
  logic       dmem_ack;
  logic       dmem_req;
  logic       PC_Write;
  logic       IF_ID_Write;
  logic       ID_EX_Bubble;
  logic       IF_ID_Flush;
  logic       ID_EX_Flush;
  logic       Pipe_Hold;
  logic       mem_timeout;
  logic [1:0] state;
`ifdef HAZARD_STALL_COUNT_EN
  logic [7:0] stall_count;
`endif

  // Pipeline side
  modport master (
    output ID_RegRs, ID_RegRt,
    output EX_RegRt, EX_MemRead,
    output EX_BranchTaken,
    output MEM_MemAccess, dmem_ack,
    input  dmem_req, PC_Write,
    input  IF_ID_Write, ID_EX_Bubble,
    input  IF_ID_Flush, ID_EX_Flush,
    input  Pipe_Hold, mem_timeout,
    input  state
`ifdef HAZARD_STALL_COUNT_EN
    , input stall_count
`endif
  );

  // Controller side
  modport slave (
    input  ID_RegRs, ID_RegRt,
    input  EX_RegRt, EX_MemRead,
    input  EX_BranchTaken,
    input  MEM_MemAccess, dmem_ack,
    output dmem_req, PC_Write,
    output IF_ID_Write, ID_EX_Bubble,
    output IF_ID_Flush, ID_EX_Flush,
    output Pipe_Hold, mem_timeout,
    output state
`ifdef HAZARD_STALL_COUNT_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard FSM: memory wait, branch flush, load-use stall.
// Define HAZARD_STALL_COUNT_EN to add the saturating stall_count output.
module hazard_controller (
  input logic                clk,
  input logic                rst_n,
  hazard_controller_if.slave bus
);
  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_wait_cnt;
  logic       r_timeout;
  logic       w_hazard;
  logic       w_mem_stall;
  logic       w_to_hit;
  logic       w_req;
  logic       w_pcw;
  logic       w_ifw;
  logic       w_bub;
  logic       w_flush;
  logic       w_hold;

  assign w_hazard = bus.EX_MemRead
                  && (bus.EX_RegRt != 1'b0)
                  && ((bus.EX_RegRt == bus.ID_RegRs)
                   || (bus.EX_RegRt == bus.ID_RegRt));

  assign w_mem_stall = bus.MEM_MemAccess && !bus.dmem_ack;

  // Fifteenth MEM_WAIT cycle still without ack
  assign w_to_hit = (r_state == MEM_WAIT)
                  && !bus.dmem_ack
                  && (r_wait_cnt == 4'd14);

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state != MEM_WAIT && w_next == MEM_WAIT)
        r_wait_cnt <= '0;
      else if (r_state == MEM_WAIT)
        r_wait_cnt <= r_wait_cnt + 4'd1;
      if (w_to_hit)
        r_timeout <= 1'b1;
    end
  end

  // Next state and pipeline controls, priority mem > branch > load-use
  always_comb begin
    w_next  = RUN;
    w_req   = 1'b0;
    w_pcw   = 1'b1;
    w_ifw   = 1'b1;
    w_bub   = 1'b0;
    w_flush = 1'b0;
    w_hold  = 1'b0;
    case (r_state)
      RUN: begin
        w_req = bus.MEM_MemAccess;
        if (w_mem_stall) begin
          w_hold = 1'b1;
          w_pcw  = 1'b0;
          w_ifw  = 1'b0;
          w_next = MEM_WAIT;
        end else if (bus.EX_BranchTaken) begin
          w_flush = 1'b1;
        end else if (w_hazard) begin
          w_pcw  = 1'b0;
          w_ifw  = 1'b0;
          w_bub  = 1'b1;
          w_next = LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        w_req = bus.MEM_MemAccess;
        if (w_mem_stall) begin
          w_hold = 1'b1;
          w_pcw  = 1'b0;
          w_ifw  = 1'b0;
          w_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        w_req  = 1'b1;
        w_hold = 1'b1;
        w_pcw  = 1'b0;
        w_ifw  = 1'b0;
        if (!bus.dmem_ack && !w_to_hit)
          w_next = MEM_WAIT;
      end
      default: w_next = RUN;
    endcase
    if (!rst_n) begin
      w_req   = 1'b0;
      w_pcw   = 1'b1;
      w_ifw   = 1'b1;
      w_bub   = 1'b0;
      w_flush = 1'b0;
      w_hold  = 1'b0;
    end
  end

  assign bus.dmem_req     = w_req;
  assign bus.PC_Write     = w_pcw;
  assign bus.IF_ID_Write  = w_ifw;
  assign bus.ID_EX_Bubble = w_bub;
  assign bus.IF_ID_Flush  = w_flush;
  assign bus.ID_EX_Flush  = w_flush;
  assign bus.Pipe_Hold    = w_hold;
  assign bus.mem_timeout  = r_timeout;
  assign bus.state        = r_state;

`ifdef HAZARD_STALL_COUNT_EN
  logic [7:0] r_stall_cnt;

  // Saturating count of cycles with the PC frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (!w_pcw && r_stall_cnt != 8'hFF)
      r_stall_cnt <= r_stall_cnt + 8'd1;
  end

  assign bus.stall_count = r_stall_cnt;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller.
// Directed scenarios plus randomized run against a reference model.
module tb_hazard_controller;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hazard_controller_if hif();

  hazard_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector:
  // {req,pcw,ifw,bub,iff,exf,hold,to,state}
  localparam logic [9:0] IDLE  = 10'b0110000000;
  localparam logic [9:0] ENTRY = 10'b1000001000;
  localparam logic [9:0] WAIT  = 10'b1000001010;
  localparam logic [9:0] FLUSH = 10'b0110110000;
  localparam logic [9:0] BUBL  = 10'b0001000000;
  localparam logic [9:0] LDST  = 10'b0110000001;

  function automatic logic [9:0] obs();
    return {hif.dmem_req, hif.PC_Write,
            hif.IF_ID_Write, hif.ID_EX_Bubble,
            hif.IF_ID_Flush, hif.ID_EX_Flush,
            hif.Pipe_Hold, hif.mem_timeout,
            hif.state};
  endfunction

  task automatic set_in(
    input logic rs, input logic rt,
    input logic exrt, input logic ld,
    input logic br, input logic acc,
    input logic ack);
    hif.ID_RegRs       = rs;
    hif.ID_RegRt       = rt;
    hif.EX_RegRt       = exrt;
    hif.EX_MemRead     = ld;
    hif.EX_BranchTaken = br;
    hif.MEM_MemAccess  = acc;
    hif.dmem_ack       = ack;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [9:0] v;
    rst_n = 1'b0;
    set_in(1, 1, 1, 1, 1, 1, 0);
    #3;
    v = obs();
    checks++;
    if (v !== IDLE) begin
      errors++;
      $display("FAIL reset_idle: got %b want %b", v, IDLE);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    v = obs();
    checks++;
    if (v !== IDLE) begin
      errors++;
      $display("FAIL after_reset: got %b want %b", v, IDLE);
    end
    next_cycle();
  endtask

  task automatic test_load_use;
    logic [9:0] v;
    set_in(1, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    v = obs();
    checks++;
    if (v !== BUBL) begin
      errors++;
      $display("FAIL load_use_bubble: got %b want %b", v, BUBL);
    end
    next_cycle();
    @(negedge clk);
    v = obs();
    checks++;
    if (v !== LDST) begin
      errors++;
      $display("FAIL load_stall_state: got %b want %b", v, LDST);
    end
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    v = obs();
    checks++;
    if (v !== IDLE) begin
      errors++;
      $display("FAIL load_use_return: got %b want %b", v, IDLE);
    end
    next_cycle();
  endtask

  task automatic test_reg0;
    logic [9:0] v;
    set_in(0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    v = obs();
    checks++;
    if (v !== IDLE) begin
      errors++;
      $display("FAIL reg0_no_stall: got %b want %b", v, IDLE);
    end
    next_cycle();
    set_in(0, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    v = obs();
    checks++;
    if (v !== IDLE) begin
      errors++;
      $display("FAIL no_match: got %b want %b", v, IDLE);
    end
    next_cycle();
    set_in(0, 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    v = obs();
    checks++;
    if (v !== BUBL) begin
      errors++;
      $display("FAIL rt_match: got %b want %b", v, BUBL);
    end
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
  endtask

  task automatic test_mem_wait;
    logic [9:0] v;
    logic [9:0] want;
    set_in(0, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) hif.dmem_ack = 1'b1;
      want = (c == 0) ? ENTRY : WAIT;
      @(negedge clk);
      v = obs();
      checks++;
      if (v !== want) begin
        errors++;
        $display("FAIL mem_wait c%0d: got %b want %b", c, v, want);
      end
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    v = obs();
    checks++;
    if (v !== IDLE) begin
      errors++;
      $display("FAIL mem_wait_done: got %b want %b", v, IDLE);
    end
    next_cycle();
  endtask

  task automatic test_timeout;
    logic [9:0] v;
    logic [9:0] want;
    set_in(0, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c <= 15; c++) begin
      want = (c == 0) ? ENTRY : WAIT;
      @(negedge clk);
      v = obs();
      checks++;
      if (v !== want) begin
        errors++;
        $display("FAIL timeout_wait c%0d: got %b want %b", c, v, want);
      end
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    want = IDLE | 10'b0000000100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      v = obs();
      checks++;
      if (v !== want) begin
        errors++;
        $display("FAIL timeout_sticky c%0d: got %b want %b", c, v, want);
      end
      next_cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    v = obs();
    checks++;
    if (v !== IDLE) begin
      errors++;
      $display("FAIL timeout_clear: got %b want %b", v, IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_coincident;
    logic [9:0] v;
    set_in(1, 0, 1, 1, 1, 0, 0);
    @(negedge clk);
    v = obs();
    checks++;
    if (v !== FLUSH) begin
      errors++;
      $display("FAIL br_vs_load: got %b want %b", v, FLUSH);
    end
    next_cycle();
    set_in(0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    v = obs();
    checks++;
    if (v !== ENTRY) begin
      errors++;
      $display("FAIL br_vs_mem: got %b want %b", v, ENTRY);
    end
    next_cycle();
    hif.dmem_ack = 1'b1;
    @(negedge clk);
    v = obs();
    checks++;
    if (v !== WAIT) begin
      errors++;
      $display("FAIL br_in_wait: got %b want %b", v, WAIT);
    end
    next_cycle();
    set_in(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    v = obs();
    checks++;
    if (v !== FLUSH) begin
      errors++;
      $display("FAIL br_deferred: got %b want %b", v, FLUSH);
    end
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
  endtask

  task automatic test_reset_mid_wait;
    logic [9:0] v;
    set_in(0, 0, 0, 0, 0, 1, 0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    v = obs();
    checks++;
    if (v !== WAIT) begin
      errors++;
      $display("FAIL pre_reset_wait: got %b want %b", v, WAIT);
    end
    #2;
    rst_n = 1'b0;
    #1;
    v = obs();
    checks++;
    if (v !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_wait: got %b want %b", v, IDLE);
    end
`ifdef HAZARD_STALL_COUNT_EN
    checks++;
    if (hif.stall_count !== 8'd0) begin
      errors++;
      $display("FAIL stall_count_reset: got %0d want 0", hif.stall_count);
    end
`endif
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_random;
    int mode;
    int waited;
    int nmode;
    int nwait;
    int ack_pct;
    logic to;
    logic nto;
    logic rs, rt, exrt, ld, br, acc, ack;
    logic hz, req, pcw, ifw, bub, fl, hold;
    logic [9:0] want;
    logic [9:0] v;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    next_cycle();
    mode = 0;
    waited = 0;
    to = 1'b0;
    ack_pct = 50;
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 2))
          0: ack_pct = 0;
          1: ack_pct = 25;
          default: ack_pct = 70;
        endcase
      end
      rs   = 1'($urandom_range(0, 1));
      rt   = 1'($urandom_range(0, 1));
      exrt = 1'($urandom_range(0, 1));
      ld   = ($urandom_range(0, 99) < 50);
      br   = ($urandom_range(0, 99) < 20);
      acc  = ($urandom_range(0, 99) < 30);
      ack  = ($urandom_range(0, 99) < ack_pct);
      set_in(rs, rt, exrt, ld, br, acc, ack);
      hz = ld && exrt && (exrt == rs || exrt == rt);
      req = 1'b0; pcw = 1'b1; ifw = 1'b1;
      bub = 1'b0; fl = 1'b0; hold = 1'b0;
      nmode = 0; nwait = waited; nto = to;
      if (mode == 2) begin
        req = 1'b1; hold = 1'b1;
        pcw = 1'b0; ifw = 1'b0;
        if (!ack) begin
          nwait = waited + 1;
          if (nwait == 15) nto = 1'b1;
          else nmode = 2;
        end
      end else begin
        req = acc;
        if (acc && !ack) begin
          hold = 1'b1; pcw = 1'b0; ifw = 1'b0;
          nmode = 2; nwait = 0;
        end else if (mode == 0 && br) begin
          fl = 1'b1;
        end else if (mode == 0 && hz) begin
          pcw = 1'b0; ifw = 1'b0; bub = 1'b1;
          nmode = 1;
        end
      end
      want = {req, pcw, ifw, bub, fl, fl, hold, to, 2'(mode)};
      @(negedge clk);
      v = obs();
      checks++;
      if (v !== want) begin
        errors++;
        $display("FAIL random c%0d: got %b want %b", i, v, want);
      end
      mode = nmode;
      waited = nwait;
      to = nto;
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_load_use();
    test_reg0();
    test_mem_wait();
    test_timeout();
    test_coincident();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports ID_RegRs, ID_RegRt, input, 1 each, source register indices of the instruction in ID.
REQ-004 SHALL have ports EX_RegRt, input, 1, and EX_MemRead, input, 1, marking a load in EX and its destination.
REQ-005 SHALL have port EX_BranchTaken, input, 1, a branch resolved taken in EX.
REQ-006 SHALL have ports MEM_MemAccess, input, 1, a load/store in MEM, and dmem_ack, input, 1, data-memory completion.
REQ-007 SHALL have port dmem_req, output, 1, the data-memory request strobe.
REQ-008 SHALL have ports PC_Write, IF_ID_Write, output, 1 each, with 1 meaning update.
REQ-009 SHALL have ports ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, output, 1 each, with 1 meaning zero the control fields.
REQ-010 SHALL have port Pipe_Hold, output, 1, freezing ID/EX, EX/MEM and MEM/WB.
REQ-011 SHALL have port mem_timeout, output, 1, a sticky error flag.
REQ-012 SHALL have port state, output, 2, the current FSM state for debug.

Function
REQ-013 SHALL implement FSM states RUN=2'b00, LOAD_STALL=2'b01, MEM_WAIT=2'b10; 2'b11 is illegal and SHALL return to RUN on the next edge with all outputs at RUN-idle values.
REQ-014 SHALL treat a load-use hazard as EX_MemRead & (EX_RegRt!=0) & (EX_RegRt==ID_RegRs | EX_RegRt==ID_RegRt), with register 0 never hazarding.
REQ-015 SHALL give event priority memory-wait > branch flush > load-use stall, each evaluated combinationally in RUN.
REQ-016 SHALL, in RUN with MEM_MemAccess=1, drive dmem_req=1; if dmem_ack=1 in the same cycle, no stall occurs, else next state = MEM_WAIT and Pipe_Hold=PC_Write/IF_ID_Write gating applies this cycle.
REQ-017 SHALL, in MEM_WAIT, hold dmem_req=1, Pipe_Hold=1, PC_Write=0, IF_ID_Write=0, no flush/bubble; on dmem_ack=1, return to RUN next edge.
REQ-018 SHALL run a 4-bit wait counter cleared on MEM_WAIT entry and incremented each MEM_WAIT cycle; on reaching 15 without ack, set mem_timeout=1 (sticky until reset), drop dmem_req and return to RUN.
REQ-019 SHALL, in RUN with EX_BranchTaken=1 and no memory wait, assert IF_ID_Flush=1 and ID_EX_Flush=1 for that cycle only, with PC_Write=1 and state remaining RUN.
REQ-020 SHALL defer a branch coinciding with a memory wait, re-evaluating it in the RUN cycle after ack, since EX is frozen.
REQ-021 SHALL suppress a load-use stall coinciding with a taken branch; the flush removes the dependent instruction.
REQ-022 SHALL, in RUN on a load-use hazard, drive PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 and next state = LOAD_STALL.
REQ-023 SHALL hold LOAD_STALL exactly one cycle with PC_Write=IF_ID_Write=1, no bubble and hazard check ignored, then return to RUN; if MEM_MemAccess=1 without ack, it SHALL go to MEM_WAIT instead.
REQ-024 SHALL use RUN-idle outputs of PC_Write=1, IF_ID_Write=1 and all other outputs 0.

Reset
REQ-025 SHALL, on rst_n=0 (any state, including mid MEM_WAIT), immediately force state=RUN, wait counter=0, mem_timeout=0 and dmem_req=0, with outputs at RUN-idle values.
REQ-026 SHALL act on the first rising clk edge after rst_n deasserts with normal evaluation.

Configuration
REQ-027 SHALL, with HAZARD_STALL_COUNT_EN defined, add output stall_count, 8 bits, counting cycles with PC_Write=0, saturating at 255, cleared by reset.
REQ-028 SHALL, without HAZARD_STALL_COUNT_EN, have no stall_count port or counter, with all other behaviour identical.

Verification
REQ-029 SHALL cover load-use: EX_MemRead=1, EX_RegRt=1, ID_RegRs=1 -> one cycle PC_Write=0, ID_EX_Bubble=1, state 01, then RUN.
REQ-030 SHALL cover register 0: EX_MemRead=1, EX_RegRt=0, ID_RegRs=0 -> no stall, outputs RUN-idle.
REQ-031 SHALL cover a 3-cycle memory wait: MEM_MemAccess=1, dmem_ack low 3 cycles -> Pipe_Hold=1 and dmem_req=1 for 3 cycles, RUN after ack, mem_timeout=0.
REQ-032 SHALL cover timeout: dmem_ack never asserted -> mem_timeout=1 after 15 MEM_WAIT cycles, stays 1 until rst_n=0.
REQ-033 SHALL cover coincident events: EX_BranchTaken=1 with a load-use hazard -> flushes asserted, no bubble; with a pending memory wait -> flush delayed until the cycle after ack.
REQ-034 SHALL cover reset mid MEM_WAIT: rst_n=0 -> state=00, dmem_req=0 asynchronously; with HAZARD_STALL_COUNT_EN, stall_count=0.
